// File: rtl/word_picker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// word_picker
// -----------------------------------------------------------------------------
// Secret-word source for the Hangman guess checker. When a new game is
// requested, a free-running 16-bit Galois LFSR picks one of 16 words from an
// internal ROM. The chosen word is held on registered outputs with a valid
// flag until the next request is accepted.
//
// Letter encoding: A=0 ... Z=25. 5'b11111 marks an unused letter position.
//
// Optional feature macro:
//   WORD_NO_REPEAT_EN - when defined, a pick never reuses the index of the
//                       previously loaded word. S_PICK resamples the LFSR
//                       (one extra cycle per retry) until the candidate
//                       differs. When undefined, S_PICK always takes one cycle.
//
// Parameters:
//   SEED  LFSR value loaded on reset (must be nonzero)
//   TAPS  Galois feedback mask, applied when the shifted-out bit is 1
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_new_game     level request; a 0->1 change between clock samples
//                  starts a pick (ignored while o_busy is high)
//   o_letter1..5   letter codes of the current word (5'b11111 when unused)
//   o_word_len     4 or 5 letters; 0 while no word is valid
//   o_word_index   ROM index of the current word (kept while invalid)
//   o_word_valid   letters, length and index are stable and usable
//   o_busy         pick in progress (S_PICK, S_FETCH, S_LOAD)
// -----------------------------------------------------------------------------
module word_picker #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_new_game,
  output logic [4:0] o_letter1,
  output logic [4:0] o_letter2,
  output logic [4:0] o_letter3,
  output logic [4:0] o_letter4,
  output logic [4:0] o_letter5,
  output logic [2:0] o_word_len,
  output logic [3:0] o_word_index,
  output logic       o_word_valid,
  output logic       o_busy
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_READY = 3'd4
  } state_t;

  // One ROM entry: length plus the five letter slots, left to right.
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] l1;
    logic [4:0] l2;
    logic [4:0] l3;
    logic [4:0] l4;
    logic [4:0] l5;
  } word_t;

  localparam logic [4:0] L_NONE = 5'd31;
  localparam logic [4:0] L_A    = 5'd0;
  localparam logic [4:0] L_B    = 5'd1;
  localparam logic [4:0] L_C    = 5'd2;
  localparam logic [4:0] L_D    = 5'd3;
  localparam logic [4:0] L_E    = 5'd4;
  localparam logic [4:0] L_F    = 5'd5;
  localparam logic [4:0] L_G    = 5'd6;
  localparam logic [4:0] L_H    = 5'd7;
  localparam logic [4:0] L_I    = 5'd8;
  localparam logic [4:0] L_K    = 5'd10;
  localparam logic [4:0] L_L    = 5'd11;
  localparam logic [4:0] L_M    = 5'd12;
  localparam logic [4:0] L_O    = 5'd14;
  localparam logic [4:0] L_P    = 5'd15;
  localparam logic [4:0] L_R    = 5'd17;
  localparam logic [4:0] L_S    = 5'd18;
  localparam logic [4:0] L_T    = 5'd19;
  localparam logic [4:0] L_W    = 5'd22;
  localparam logic [4:0] L_Y    = 5'd24;

  // "No word" pattern: length 0, every position marked unused.
  localparam word_t BLANK_WORD = '{len: 3'd0, l1: L_NONE, l2: L_NONE,
                                   l3: L_NONE, l4: L_NONE, l5: L_NONE};

  // ---------------------------------------------------------------------------
  // Word ROM
  // ---------------------------------------------------------------------------
  // NOTE: the ROM is a constant case table, so there is no storage to reset;
  // only the registers that capture its output are reset.
  function automatic word_t f_rom(input logic [3:0] idx);
    word_t w;
    case (idx)
      4'd0:    w = {3'd4, L_S, L_T, L_A, L_Y, L_NONE};  // STAY
      4'd1:    w = {3'd4, L_G, L_A, L_M, L_E, L_NONE};  // GAME
      4'd2:    w = {3'd4, L_W, L_O, L_R, L_D, L_NONE};  // WORD
      4'd3:    w = {3'd4, L_L, L_O, L_C, L_K, L_NONE};  // LOCK
      4'd4:    w = {3'd4, L_B, L_Y, L_T, L_E, L_NONE};  // BYTE
      4'd5:    w = {3'd4, L_G, L_A, L_T, L_E, L_NONE};  // GATE
      4'd6:    w = {3'd4, L_W, L_I, L_R, L_E, L_NONE};  // WIRE
      4'd7:    w = {3'd4, L_C, L_H, L_I, L_P, L_NONE};  // CHIP
      4'd8:    w = {3'd5, L_A, L_D, L_D, L_E, L_R};     // ADDER
      4'd9:    w = {3'd5, L_L, L_A, L_T, L_C, L_H};     // LATCH
      4'd10:   w = {3'd5, L_C, L_L, L_O, L_C, L_K};     // CLOCK
      4'd11:   w = {3'd5, L_L, L_O, L_G, L_I, L_C};     // LOGIC
      4'd12:   w = {3'd5, L_R, L_E, L_S, L_E, L_T};     // RESET
      4'd13:   w = {3'd5, L_D, L_E, L_L, L_A, L_Y};     // DELAY
      4'd14:   w = {3'd5, L_F, L_L, L_A, L_S, L_H};     // FLASH
      default: w = {3'd5, L_T, L_I, L_M, L_E, L_R};     // TIMER (15)
    endcase
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and internal wires
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_lfsr;
  logic        r_new_game_q;
  logic [3:0]  r_cand;        // candidate index sampled in S_PICK
  word_t       r_rom;         // registered ROM read from S_FETCH
  word_t       r_word;        // word presented on the outputs
  logic [3:0]  r_word_index;  // also serves as last_index for repeat checks
  logic        r_word_valid;
  logic        r_busy;
`ifdef WORD_NO_REPEAT_EN
  logic        r_have_word;   // a word has been loaded since reset
`endif

  logic [15:0] w_lfsr_next;
  logic        w_new_game_rise;
  logic        w_repeat;

  // ---------------------------------------------------------------------------
  // LFSR: right-shifting Galois form, free-running outside reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned (which would infer a latch).
    w_lfsr_next = {1'b0, r_lfsr[15:1]};
    if (r_lfsr[0]) begin
      w_lfsr_next = w_lfsr_next ^ TAPS;
    end
    // The all-zero state would lock up the LFSR forever; recover from it.
    if (r_lfsr == 16'h0000) begin
      w_lfsr_next = SEED;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Request edge detect. r_new_game_q resets to 0, so a request held high
  // through reset release is seen as exactly one edge.
  // ---------------------------------------------------------------------------
  assign w_new_game_rise = i_new_game & ~r_new_game_q;

  // Candidate rejection: only possible with the no-repeat option.
`ifdef WORD_NO_REPEAT_EN
  assign w_repeat = r_have_word && (r_lfsr[3:0] == r_word_index);
`else
  assign w_repeat = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_new_game_q <= 1'b0;
      r_cand       <= 4'd0;
      r_rom        <= BLANK_WORD;
      r_word       <= BLANK_WORD;
      r_word_index <= 4'd0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
`ifdef WORD_NO_REPEAT_EN
      r_have_word  <= 1'b0;
`endif
    end else begin
      r_new_game_q <= i_new_game;

      case (r_state)
        // Edges are only accepted here; anything arriving while busy is
        // simply dropped. The index is kept so the repeat check still works.
        S_IDLE, S_READY: begin
          if (w_new_game_rise) begin
            r_state      <= S_PICK;
            r_busy       <= 1'b1;
            r_word_valid <= 1'b0;
            r_word       <= BLANK_WORD;
          end
        end

        // On a rejected candidate stay here; the LFSR has moved on by the
        // next cycle, so the resample sees a fresh value.
        S_PICK: begin
          if (!w_repeat) begin
            r_cand  <= r_lfsr[3:0];
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          r_rom   <= f_rom(r_cand);
          r_state <= S_LOAD;
        end

        S_LOAD: begin
          r_word       <= r_rom;
          r_word_index <= r_cand;
          r_word_valid <= 1'b1;
          r_busy       <= 1'b0;
`ifdef WORD_NO_REPEAT_EN
          r_have_word  <= 1'b1;
`endif
          r_state      <= S_READY;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers, no combinational path from i_new_game.
  // ---------------------------------------------------------------------------
  assign o_letter1    = r_word.l1;
  assign o_letter2    = r_word.l2;
  assign o_letter3    = r_word.l3;
  assign o_letter4    = r_word.l4;
  assign o_letter5    = r_word.l5;
  assign o_word_len   = r_word.len;
  assign o_word_index = r_word_index;
  assign o_word_valid = r_word_valid;
  assign o_busy       = r_busy;

endmodule
